// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: scans a snapshotted hex value across NUM_DIGITS digits through one shared decoder
//   clk, rst     : clock, synchronous active-high reset
//   en           : scan enable, sampled in IDLE and in the final gap of a frame
//   value        : packed nibbles, digit i = value[4i+3:4i], captured at frame start
//   blank_mask   : 1 = keep digit i dark (read live)
//   dec_in       : nibble to the shared decoder
//   dec_seg      : segments back from the shared decoder
//   seg          : segment pins, active-high
//   digit_sel    : one-hot digit enable, active-high
//   frame_done   : 1-cycle pulse in the last gap of each frame
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [3:0]              dec_in,
   input  logic [6:0]              dec_seg,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHOW = 2'd2, GAP = 2'd3;
   logic [1:0]              state;
   logic [IW-1:0]           idx;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] snapshot, shifted;
   logic                    last_digit, slot_end, show, lit;
   assign last_digit = idx == IW'(NUM_DIGITS - 1);
   assign slot_end   = cnt == CW'(PRESCALE - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         cnt      <= '0;
         snapshot <= '0;
      end else begin
         case (state)
            IDLE: state <= en ? LOAD : IDLE;
            LOAD: begin
               snapshot <= value;
               idx      <= '0;
               cnt      <= '0;
               state    <= SHOW;
            end
            SHOW: begin
               cnt   <= cnt + 1'b1;
               state <= slot_end ? GAP : SHOW;
            end
            default: begin
               cnt   <= '0;
               idx   <= last_digit ? idx : idx + 1'b1;
               state <= last_digit ? (en ? LOAD : IDLE) : SHOW;
            end
         endcase
      end
   end
   // shifting instead of a part-select keeps the digit index at its natural width
   assign shifted    = snapshot >> {idx, 2'b00};
   assign show       = state == SHOW;
   assign lit        = show && !blank_mask[idx];
   assign dec_in     = show ? shifted[3:0] : 4'd0;
   assign seg        = lit ? dec_seg : 7'd0;
   assign digit_sel  = lit ? NUM_DIGITS'(1) << idx : '0;
   assign frame_done = state == GAP && last_digit;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed and random checks of the scan controller against a frame-position model
module tb_seven_seg_scan_ctrl;
   localparam int N  = 4;
   localparam int P  = 4;
   localparam int FP = 1 + N * (P + 1);
   logic           clk = 0, rst, en, frame_done;
   logic [4*N-1:0] value;
   logic [N-1:0]   blank_mask, digit_sel;
   logic [3:0]     dec_in;
   logic [6:0]     dec_seg, seg;
   int checks = 0, failures = 0;
   logic [6:0] rom [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   bit             m_act = 0;
   int             m_t = 0;
   logic [4*N-1:0] m_snap = '0;
   always #5 clk = ~clk;
   assign dec_seg = rom[dec_in];
   seven_seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
      .clk(clk), .rst(rst), .en(en), .value(value), .blank_mask(blank_mask),
      .dec_in(dec_in), .dec_seg(dec_seg), .seg(seg), .digit_sel(digit_sel),
      .frame_done(frame_done)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      int u, d;
      bit sh;
      logic [3:0] nib;
      @(posedge clk);
      if (rst) begin
         m_act = 0;
         m_t = 0;
         m_snap = '0;
      end else if (!m_act) begin
         m_act = en;
         m_t = 0;
      end else begin
         if (m_t == 0) m_snap = value;
         if (m_t == FP - 1) begin
            m_act = en;
            m_t = 0;
         end else m_t++;
      end
      @(negedge clk);
      u = m_t - 1;
      d = u / (P + 1);
      sh = m_act && m_t > 0 && (u % (P + 1)) < P;
      nib = 4'((m_snap >> (4 * d)) & 'hF);
      chk("digit_sel", 32'(digit_sel), (sh && !blank_mask[d]) ? 32'(1) << d : 0);
      chk("seg", 32'(seg), (sh && !blank_mask[d]) ? 32'(rom[nib]) : 0);
      chk("frame_done", 32'(frame_done), 32'(m_act && m_t == FP - 1));
      chk("onehot", 32'($countones(digit_sel) <= 1), 1);
      if (sh) chk("dec_in", 32'(dec_in), 32'(nib));
      if (!m_act) chk("dec_in_idle", 32'(dec_in), 0);
   endtask
   initial begin
      rst = 1; en = 1; value = '0; blank_mask = '0;
      repeat (2) cyc();
      chk("reset_sel", 32'(digit_sel), 0);
      rst = 0; value = 16'h2300;
      repeat (21) cyc();
      chk("frame_at_21", 32'(frame_done), 1);
      repeat (7) cyc();
      value = 16'hFFFF;
      repeat (14) cyc();
      repeat (21) cyc();
      blank_mask = 4'b1010;
      repeat (21) cyc();
      chk("blank_frame_at_21", 32'(frame_done), 1);
      blank_mask = '0;
      repeat (7) cyc();
      en = 0;
      repeat (14) cyc();
      chk("en_drop_done", 32'(frame_done), 1);
      repeat (3) cyc();
      chk("idle_sel", 32'(digit_sel), 0);
      en = 1;
      repeat (13) cyc();
      rst = 1;
      cyc();
      chk("midreset_seg", 32'(seg), 0);
      rst = 0; value = 16'hABCD;
      repeat (21) cyc();
      repeat (800) begin
         rst = $urandom_range(0, 99) == 0;
         en = $urandom_range(0, 7) != 0;
         value = 16'($urandom);
         blank_mask = 4'($urandom);
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
